burst_clk_divider: RTL

Runtime-programmable clock divider producing a divided clock with idle-high level, rise/fall strobes, and an optional bounded burst of N clock cycles. Successor to the fixed-rate divider: the half-period is set per run instead of by parameter, and a run either free-runs until stopped or ends itself after a programmed number of rising edges. It sits between the display controller FSM and the serial shift-out logic, which consumes `o_rose_stb`/`o_fell_stb` as clock enables in the `i_clk` domain.

---
 rtl/burst_clk_divider_pkg.sv | 13 +
 rtl/burst_clk_divider_half_period_counter.sv | 41 ++++
 rtl/burst_clk_divider.sv | 134 +++++++++++++
 3 files changed

// File: rtl/burst_clk_divider_pkg.sv
// rtl/burst_clk_divider_pkg.sv - shared states, default widths and idle level for the burst clock divider
package clk_div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int   DEF_DIV_WIDTH = 12;
  localparam int   DEF_CNT_WIDTH = 8;
  localparam logic IDLE_LEVEL    = 1'b1;

endpackage

// File: rtl/burst_clk_divider_half_period_counter.sv
// rtl/burst_clk_divider_half_period_counter.sv - loadable down-counter that self-reloads on reaching zero
module half_period_counter
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DEF_DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] reload_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = reload_i;
    end else if (en_i) begin
      // Reloading at zero keeps a steady H'-cycle cadence with no gap cycle.
      count_d = (count_q == '0) ? reload_i : count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/burst_clk_divider.sv
// rtl/burst_clk_divider.sv - runtime-programmable divided clock with rise/fall strobes and bounded bursts
module burst_clk_divider
  import clk_div_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [DIV_WIDTH-1:0] i_half_period,
  input  logic [CNT_WIDTH-1:0] i_burst_len,
  input  logic                 i_start_stb,
  input  logic                 i_stop_stb,
  output logic                 o_div_clk,
  output logic                 o_rose_stb,
  output logic                 o_fell_stb,
  output logic                 o_busy,
  output logic                 o_done_stb
);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] half_q, half_d;
  logic [CNT_WIDTH-1:0] burst_q, burst_d;
  logic [CNT_WIDTH-1:0] rise_q, rise_d;
  logic [CNT_WIDTH-1:0] rise_next;
  logic                 div_clk_q, div_clk_d;
  logic                 rose_q, rose_d;
  logic                 fell_q, fell_d;
  logic                 done_q, done_d;

  logic                 cnt_clr, cnt_load, cnt_en, cnt_zero;
  logic [DIV_WIDTH-1:0] cnt_reload;
  logic [DIV_WIDTH-1:0] start_half;

  // H' - 1, with a programmed 0 behaving like 1.
  assign start_half = (i_half_period == '0) ? '0 : i_half_period - 1'b1;
  assign rise_next  = rise_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    burst_d    = burst_q;
    rise_d     = rise_q;
    div_clk_d  = div_clk_q;
    rose_d     = 1'b0;
    fell_d     = 1'b0;
    done_d     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_reload = half_q;

    case (state_q)
      ST_IDLE: begin
        div_clk_d = IDLE_LEVEL;
        if (i_start_stb && !i_stop_stb) begin
          half_d     = start_half;
          burst_d    = i_burst_len;
          rise_d     = '0;
          cnt_load   = 1'b1;
          cnt_reload = start_half;
          state_d    = ST_RUN;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_stop_stb) begin
          // Abort forces the idle level silently: no rise or done strobe.
          div_clk_d = IDLE_LEVEL;
          cnt_load  = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_zero) begin
            div_clk_d = ~div_clk_q;
            if (div_clk_q) begin
              fell_d = 1'b1;
            end else begin
              rose_d = 1'b1;
              rise_d = rise_next;
              if (burst_q != '0 && rise_next == burst_q) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      half_q    <= '0;
      burst_q   <= '0;
      rise_q    <= '0;
      div_clk_q <= IDLE_LEVEL;
      rose_q    <= 1'b0;
      fell_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      burst_q   <= burst_d;
      rise_q    <= rise_d;
      div_clk_q <= div_clk_d;
      rose_q    <= rose_d;
      fell_q    <= fell_d;
      done_q    <= done_d;
    end
  end

  half_period_counter #(
    .WIDTH(DIV_WIDTH)
  ) u_half_cnt (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .clr_i    (cnt_clr),
    .load_i   (cnt_load),
    .en_i     (cnt_en),
    .reload_i (cnt_reload),
    .zero_o   (cnt_zero)
  );

  assign o_div_clk  = div_clk_q;
  assign o_rose_stb = rose_q;
  assign o_fell_stb = fell_q;
  assign o_done_stb = done_q;
  assign o_busy     = (state_q == ST_RUN);

endmodule
